// File: rtl/morse_pkg.sv
// Shared types and constants for the morse keyer: FSM states, code-word symbols,
// unit lengths and small helpers for decoding a 10-bit code word.
package morse_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MARK,
    S_SPACE,
    S_CGAP
  } state_t;

  localparam logic [1:0] SYM_DOT  = 2'b01;
  localparam logic [1:0] SYM_DASH = 2'b10;
  localparam logic [1:0] SYM_PAD  = 2'b11;

  localparam logic [9:0] CODE_WORD_GAP = 10'h3FF;

  localparam logic [2:0] DOT_UNITS      = 3'd1;
  localparam logic [2:0] DASH_UNITS     = 3'd3;
  localparam logic [2:0] SYM_GAP_UNITS  = 3'd1;
  localparam logic [2:0] CHAR_GAP_UNITS = 3'd3;
  localparam logic [2:0] WORD_GAP_UNITS = 3'd7;

  function automatic logic is_mark(input logic [1:0] sym);
    return (sym == SYM_DOT) || (sym == SYM_DASH);
  endfunction

  function automatic logic [2:0] mark_units(input logic [1:0] sym);
    return (sym == SYM_DASH) ? DASH_UNITS : DOT_UNITS;
  endfunction

  // Indices past the last pair read as padding, which ends the character.
  function automatic logic [1:0] sym_at(input logic [9:0] code, input logic [2:0] idx);
    case (idx)
      3'd0:    return code[1:0];
      3'd1:    return code[3:2];
      3'd2:    return code[5:4];
      3'd3:    return code[7:6];
      3'd4:    return code[9:8];
      default: return SYM_PAD;
    endcase
  endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Counts a loaded number of morse units, each UNIT_CYCLES clocks long; units_done
// is high for the final clock of the last unit. clear wins over load.
module morse_unit_timer #(
  parameter int unsigned UNIT_CYCLES = 5_000_000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       clear,
  input  logic [2:0] load_units,
  input  logic       load,
  output logic       units_done
);

  localparam int unsigned CW = $clog2(UNIT_CYCLES);
  localparam logic [CW-1:0] CYC_LAST = CW'(UNIT_CYCLES - 1);

  logic [CW-1:0] cyc_q;
  logic [2:0]    units_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cyc_q   <= '0;
      units_q <= '0;
    end else if (clear) begin
      cyc_q   <= '0;
      units_q <= '0;
    end else if (load) begin
      cyc_q   <= '0;
      units_q <= load_units;
    end else if (units_q != 3'd0) begin
      if (cyc_q == CYC_LAST) begin
        cyc_q   <= '0;
        units_q <= units_q - 3'd1;
      end else begin
        cyc_q <= cyc_q + 1'b1;
      end
    end
  end

  assign units_done = (units_q == 3'd1) && (cyc_q == CYC_LAST);

endmodule

// File: rtl/morse_keyer.sv
// Character sequencer: accepts one ASCII char, looks up its code word and keys
// dots, dashes and gaps with exact unit timing; abort drops back to IDLE at once.
module morse_keyer
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 5_000_000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        char_valid,
  input  logic [7:0]  char_ascii,
  output logic        char_ready,
  input  logic        abort,
  output logic [31:0] lookup_ascii,
  input  logic [9:0]  lookup_code,
  output logic        key,
  output logic        busy,
  output logic        char_done
);

  state_t     state_q;
  logic [7:0] char_q;
  logic [9:0] code_q;
  logic [2:0] idx_q;
  logic       key_q;

  logic       units_done;
  logic       t_clear;
  logic       t_load;
  logic [2:0] t_units;
  logic       abort_act;
  logic [1:0] nxt_sym;
  logic       more_syms;

  assign abort_act = abort && (state_q != S_IDLE);
  assign nxt_sym   = sym_at(code_q, idx_q + 3'd1);
  assign more_syms = (idx_q < 3'd4) && is_mark(nxt_sym);

  // Timer reloads on the same edge as the state change so durations stay exact.
  always_comb begin
    t_clear = abort_act;
    t_load  = 1'b0;
    t_units = 3'd0;
    case (state_q)
      S_LOAD: begin
        t_load  = 1'b1;
        t_units = is_mark(lookup_code[1:0]) ? mark_units(lookup_code[1:0]) : WORD_GAP_UNITS;
      end
      S_MARK: begin
        t_load  = units_done;
        t_units = more_syms ? SYM_GAP_UNITS : CHAR_GAP_UNITS;
      end
      S_SPACE: begin
        t_load  = units_done;
        t_units = mark_units(nxt_sym);
      end
      default: ;
    endcase
  end

  morse_unit_timer #(
    .UNIT_CYCLES (UNIT_CYCLES)
  ) u_timer (
    .clock      (clock),
    .resetn     (resetn),
    .clear      (t_clear),
    .load_units (t_units),
    .load       (t_load),
    .units_done (units_done)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      char_q  <= '0;
      code_q  <= CODE_WORD_GAP;
      idx_q   <= '0;
      key_q   <= 1'b0;
    end else if (abort_act) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      key_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (char_valid) begin
            char_q  <= char_ascii;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          code_q <= lookup_code;
          idx_q  <= '0;
          if (is_mark(lookup_code[1:0])) begin
            state_q <= S_MARK;
            key_q   <= 1'b1;
          end else begin
            state_q <= S_CGAP;
            key_q   <= 1'b0;
          end
        end
        S_MARK: begin
          if (units_done) begin
            key_q   <= 1'b0;
            state_q <= more_syms ? S_SPACE : S_CGAP;
          end
        end
        S_SPACE: begin
          if (units_done) begin
            idx_q   <= idx_q + 3'd1;
            key_q   <= 1'b1;
            state_q <= S_MARK;
          end
        end
        S_CGAP: begin
          if (units_done) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign char_ready   = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign key          = key_q;
  assign lookup_ascii = {24'b0, char_q};
  assign char_done    = (state_q == S_CGAP) && units_done && !abort;

endmodule

// File: tb/tb_morse_keyer.sv
// Bench for morse_keyer: a schedule-based model predicts every output each cycle,
// backed by directed waveform measurements with hand-computed lengths.
module tb_morse_keyer;

  localparam int U = 4;

  typedef bit [1:0] ent_t;          // {key, done}
  typedef ent_t sched_t[$];

  logic        clock;
  logic        resetn;
  logic        char_valid;
  logic [7:0]  char_ascii;
  logic        char_ready;
  logic        abort;
  logic [31:0] lookup_ascii;
  logic [9:0]  lookup_code;
  logic        key;
  logic        busy;
  logic        char_done;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  function automatic logic [9:0] lut(input logic [7:0] c);
    case (c)
      8'd69:   return 10'h3FD; // E .
      8'd65:   return 10'h3F9; // A .-
      8'd48:   return 10'h2AA; // 0 -----
      8'd84:   return 10'h3FE; // T -
      8'd66:   return 10'h356; // B -...
      8'd78:   return 10'h3F6; // N -.
      8'd83:   return 10'h3D5; // S ...
      8'd53:   return 10'h155; // 5 .....
      8'd126:  return 10'h3F1; // dot then illegal 00
      8'd64:   return 10'h000; // illegal first pair
      8'd37:   return 10'h3F4; // illegal first pair, mark after
      default: return 10'h3FF; // space / unmapped
    endcase
  endfunction

  assign lookup_code = lut(lookup_ascii[7:0]);

  morse_keyer #(.UNIT_CYCLES(U)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .char_valid   (char_valid),
    .char_ascii   (char_ascii),
    .char_ready   (char_ready),
    .abort        (abort),
    .lookup_ascii (lookup_ascii),
    .lookup_code  (lookup_code),
    .key          (key),
    .busy         (busy),
    .char_done    (char_done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  // One entry per busy cycle: the LOAD cycle, then marks and gaps; done on the last.
  function automatic void build(input logic [9:0] code, output sched_t s);
    int marks[$];
    logic [1:0] p;
    s = {};
    for (int i = 0; i < 5; i++) begin
      p = code[2*i +: 2];
      if (p == 2'b01) marks.push_back(1);
      else if (p == 2'b10) marks.push_back(3);
      else break;
    end
    s.push_back(2'b00);
    if (marks.size() == 0) begin
      for (int i = 0; i < 7*U - 1; i++) s.push_back(2'b00);
    end else begin
      for (int k = 0; k < marks.size(); k++) begin
        for (int i = 0; i < marks[k]*U; i++) s.push_back(2'b10);
        if (k < marks.size() - 1)
          for (int i = 0; i < U; i++) s.push_back(2'b00);
      end
      for (int i = 0; i < 3*U - 1; i++) s.push_back(2'b00);
    end
    s.push_back(2'b01);
  endfunction

  sched_t     sched;
  sched_t     tmp;
  logic [7:0] last_char = '0;
  int         acc_cnt = 0;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sched.delete();
      last_char <= '0;
    end else if (sched.size() != 0) begin
      if (abort) sched.delete();
      else void'(sched.pop_front());
    end else if (char_valid) begin
      build(lut(char_ascii), tmp);
      foreach (tmp[i]) sched.push_back(tmp[i]);
      last_char <= char_ascii;
      acc_cnt   <= acc_cnt + 1;
    end
  end

  initial begin
    logic [35:0] act, exp_v;
    logic ek, ed, eb;
    forever begin
      @(negedge clock);
      ek = (sched.size() != 0) ? sched[0][1] : 1'b0;
      ed = (sched.size() != 0) ? (sched[0][0] && !abort) : 1'b0;
      eb = (sched.size() != 0);
      exp_v = {ek, eb, !eb, ed, 24'b0, last_char};
      act   = {key, busy, char_ready, char_done, lookup_ascii};
      n_cmp++;
      if (act !== exp_v) begin
        n_fail++;
        $display("FAIL cycle_outputs cyc=%0d got key,busy,rdy,done,ascii=%b%b%b%b,%h want %b%b%b%b,%h",
                 cyc, act[35], act[34], act[33], act[32], act[31:0],
                 exp_v[35], exp_v[34], exp_v[33], exp_v[32], exp_v[31:0]);
      end
    end
  end

  int   key_edges[$];
  int   done_cycles[$];
  int   busy_rise = 0;
  logic prev_key  = 1'b0;
  logic prev_busy = 1'b0;

  initial begin
    forever begin
      @(negedge clock);
      if (key !== prev_key) key_edges.push_back(cyc);
      prev_key = key;
      if (char_done === 1'b1) done_cycles.push_back(cyc);
      if (busy === 1'b1 && prev_busy !== 1'b1) busy_rise = cyc;
      prev_busy = busy;
    end
  end

  int eb_i;
  int db_i;

  function automatic int ek_at(input int i);
    if (eb_i + i < key_edges.size()) return key_edges[eb_i + i];
    return -1000;
  endfunction

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic snap();
    eb_i = key_edges.size();
    db_i = done_cycles.size();
  endtask

  task automatic send(input logic [7:0] ch);
    int base;
    bit ok;
    base = acc_cnt;
    ok = 0;
    char_ascii = ch;
    char_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clock); #1;
      if (acc_cnt != base) begin ok = 1; break; end
    end
    char_valid = 1'b0;
    if (!ok) check("send_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clock); #1;
      if (char_ready === 1'b1 && sched.size() == 0) begin ok = 1; break; end
    end
    if (!ok) check("idle_timeout", 0, 1);
  endtask

  task automatic wait_key_rise();
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock); #1;
      if (key === 1'b1) begin ok = 1; break; end
    end
    if (!ok) check("key_rise_timeout", 0, 1);
  endtask

  task automatic run_e(input string tag);
    snap();
    send(8'd69);
    wait_idle();
    check({tag, "_edges"}, key_edges.size() - eb_i, 2);
    check({tag, "_high"}, ek_at(1) - ek_at(0), 4);
    check({tag, "_dones"}, done_cycles.size() - db_i, 1);
  endtask

  initial begin
    sched_t p;
    int base;
    resetn     = 1'b0;
    char_valid = 1'b0;
    char_ascii = 8'd0;
    abort      = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_key", int'(key), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ready", int'(char_ready), 1);
    check("rst_done", int'(char_done), 0);
    check("rst_lookup", int'(lookup_ascii), 0);
    resetn = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    build(10'h3FD, p); check("model_len_E", p.size(), 17);
    build(10'h2AA, p); check("model_len_0", p.size(), 89);
    build(10'h3FF, p); check("model_len_space", p.size(), 29);

    // 'E': one dot, then 3-unit trailing gap.
    snap();
    send(8'd69);
    wait_idle();
    check("E_edges", key_edges.size() - eb_i, 2);
    check("E_high", ek_at(1) - ek_at(0), 4);
    check("E_load_to_rise", ek_at(0) - busy_rise, 1);
    check("E_dones", done_cycles.size() - db_i, 1);
    if (done_cycles.size() > db_i) check("E_trail_low", done_cycles[db_i] - ek_at(1) + 1, 12);
    check("E_ready_after", int'(char_ready), 1);

    // 'A': dot, gap, dash.
    snap();
    send(8'd65);
    wait_idle();
    check("A_edges", key_edges.size() - eb_i, 4);
    check("A_dot", ek_at(1) - ek_at(0), 4);
    check("A_gap", ek_at(2) - ek_at(1), 4);
    check("A_dash", ek_at(3) - ek_at(2), 12);
    check("A_dones", done_cycles.size() - db_i, 1);

    // '0': five dashes, index must stop after the fifth.
    snap();
    send(8'd48);
    wait_idle();
    check("zero_edges", key_edges.size() - eb_i, 10);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("zero_dash%0d", i), ek_at(2*i+1) - ek_at(2*i), 12);
      if (i < 4) check($sformatf("zero_gap%0d", i), ek_at(2*i+2) - ek_at(2*i+1), 4);
    end
    if (done_cycles.size() > db_i) check("zero_trail_low", done_cycles[db_i] - ek_at(9) + 1, 12);

    // Space: word gap, key never rises; accept cycle + LOAD + 28 gap cycles.
    snap();
    send(8'd32);
    wait_idle();
    check("space_edges", key_edges.size() - eb_i, 0);
    check("space_dones", done_cycles.size() - db_i, 1);
    if (done_cycles.size() > db_i) check("space_accept_to_done", done_cycles[db_i] - busy_rise + 2, 30);

    // 'T','T' with valid held throughout.
    snap();
    base = acc_cnt;
    char_ascii = 8'd84;
    char_valid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clock); #1;
      if (acc_cnt == base + 2) break;
    end
    char_valid = 1'b0;
    check("TT_accepts", acc_cnt - base, 2);
    wait_idle();
    check("TT_edges", key_edges.size() - eb_i, 4);
    check("TT_low_between", ek_at(2) - ek_at(1), 14);
    check("TT_dones", done_cycles.size() - db_i, 2);

    // Abort mid-dash of 'B'.
    snap();
    send(8'd66);
    wait_key_rise();
    repeat (5) @(posedge clock);
    #1;
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    check("abort_key", int'(key), 0);
    check("abort_ready", int'(char_ready), 1);
    repeat (30) @(posedge clock);
    #1;
    check("abort_dones", done_cycles.size() - db_i, 0);
    run_e("E_after_abort");

    // Reset pulse mid-dash of 'B'.
    send(8'd66);
    wait_key_rise();
    repeat (5) @(posedge clock);
    #1;
    resetn = 1'b0;
    #1;
    check("rstmid_key", int'(key), 0);
    check("rstmid_busy", int'(busy), 0);
    check("rstmid_ready", int'(char_ready), 1);
    check("rstmid_lookup", int'(lookup_ascii), 0);
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
    repeat (20) @(posedge clock);
    #1;
    check("rstmid_key_quiet", int'(key), 0);
    run_e("E_after_reset");

    // Randomized traffic with occasional aborts; the cycle compare does the checking.
    begin
      logic [7:0] tbl[13];
      tbl = '{8'd69, 8'd65, 8'd48, 8'd84, 8'd66, 8'd78, 8'd83,
              8'd53, 8'd126, 8'd64, 8'd37, 8'd32, 8'd90};
      for (int i = 0; i < 6000; i++) begin
        @(posedge clock); #1;
        char_valid = ($urandom_range(0, 99) < 40);
        char_ascii = tbl[$urandom_range(0, 12)];
        abort      = ($urandom_range(0, 149) == 0);
      end
    end
    char_valid = 1'b0;
    abort      = 1'b0;
    wait_idle();
    repeat (2) @(posedge clock);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
